sccb_cfg_sequencer: RTL and testbench

SCCB_CFG_SEQUENCER -- requirements
Module: sccb_cfg_sequencer

---
 rtl/sccb_cfg_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_sccb_cfg_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_sequencer.sv
// Walks a register table held in an external synchronous ROM and feeds each
// {id, sub-addr, value} word to an SCCB write engine, with power-up wait, delay markers and NACK retries.
module sccb_cfg_sequencer #(
    parameter int         CLK_FREQ  = 25_000_000,
    parameter int         SCCB_FREQ = 100_000,
    parameter logic [7:0] LUT_SIZE  = 8'd192,
    parameter int         PWR_MS    = 20,
    parameter int         RETRY_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  lut_index,
    input  logic [23:0] lut_data,
    output logic        sclk_100k,
    output logic        i2c_negclk,
    output logic        en,
    output logic [23:0] wr_data,
    input  logic        trans_finished,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic [2:0]  dbg_state
);

    localparam int               DIV       = CLK_FREQ / SCCB_FREQ;
    localparam int               DIV_W     = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(DIV / 2);
    localparam logic [DIV_W-1:0] TICK_AT   = DIV_W'(DIV / 2 - 1);
    localparam logic [31:0]      MS_TICKS  = 32'(SCCB_FREQ / 1000);
    localparam logic [31:0]      PWR_TICKS = 32'(PWR_MS * (SCCB_FREQ / 1000));
    localparam logic [31:0]      GAP_TICKS = 32'd2;
    localparam logic [7:0]       RETRY_LIM = 8'(RETRY_MAX);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PWR_WAIT = 3'd1,
        FETCH    = 3'd2,
        WRITE    = 3'd3,
        GAP      = 3'd4,
        DELAY    = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [31:0]      r_tick_cnt;
    logic [31:0]      w_wait_tgt;
    logic             w_wait_done;
    logic             w_tick;
    logic             w_start_acc;
    logic             r_fetch_ph;
    logic [7:0]       r_lut_index;
    logic [23:0]      r_wr_data;
    logic [7:0]       r_delay_ms;
    logic             r_nack;
    logic [7:0]       r_retry;
    logic             r_err;
    logic [7:0]       r_err_cnt;

    assign w_tick = (r_div_cnt == TICK_AT);

    always_comb begin
        w_wait_tgt = '0;
        case (r_state)
            PWR_WAIT: w_wait_tgt = PWR_TICKS;
            GAP:      w_wait_tgt = GAP_TICKS;
            DELAY:    w_wait_tgt = {24'd0, r_delay_ms} * MS_TICKS;
            default:  w_wait_tgt = '0;
        endcase
    end

    assign w_wait_done = (r_tick_cnt == w_wait_tgt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = PWR_WAIT;
                    w_start_acc = 1'b1;
                end
            end
            PWR_WAIT: begin
                if (w_wait_done) w_state_nxt = FETCH;
            end
            FETCH: begin
                // Phase 0 presents the address, phase 1 sees the ROM word.
                if (!r_fetch_ph) begin
                    if (r_lut_index == LUT_SIZE) w_state_nxt = DONE;
                end else if (lut_data[23:16] == 8'hFF) begin
                    w_state_nxt = DELAY;
                end else begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (trans_finished) w_state_nxt = GAP;
            end
            GAP, DELAY: begin
                if (w_wait_done) w_state_nxt = FETCH;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_fetch_ph  <= 1'b0;
            r_lut_index <= '0;
            r_wr_data   <= '0;
            r_delay_ms  <= '0;
            r_nack      <= 1'b0;
            r_retry     <= '0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;

            // Wait counter restarts on every state change so each wait starts from zero.
            if (w_state_nxt != r_state) begin
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 32'd1;
            end

            r_fetch_ph <= (r_state == FETCH) && (w_state_nxt == FETCH);

            if (w_start_acc) begin
                r_lut_index <= '0;
                r_retry     <= '0;
                r_err       <= 1'b0;
                r_err_cnt   <= '0;
            end

            if (r_state == FETCH && r_fetch_ph) begin
                if (lut_data[23:16] == 8'hFF) begin
                    r_delay_ms <= lut_data[7:0];
                end else begin
                    r_wr_data <= lut_data;
                end
            end

            if (r_state == WRITE && trans_finished) r_nack <= ack;

            if (r_state == GAP && w_wait_done) begin
                if (!r_nack) begin
                    r_lut_index <= r_lut_index + 8'd1;
                    r_retry     <= '0;
                end else if (r_retry < RETRY_LIM) begin
                    r_retry <= r_retry + 8'd1;
                end else begin
                    r_err       <= 1'b1;
                    r_err_cnt   <= (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
                    r_lut_index <= r_lut_index + 8'd1;
                    r_retry     <= '0;
                end
            end

            if (r_state == DELAY && w_wait_done) r_lut_index <= r_lut_index + 8'd1;
        end
    end

    assign sclk_100k  = (r_div_cnt < DIV_HALF);
    assign i2c_negclk = w_tick;
    assign en         = (r_state == WRITE);
    assign busy       = (r_state != IDLE) && (r_state != DONE);
    assign done       = (r_state == DONE);
    assign lut_index  = r_lut_index;
    assign wr_data    = r_wr_data;
    assign err        = r_err;
    assign err_cnt    = r_err_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: ROM and write-engine models, expected write list built from the table.
`timescale 1ns/1ps
module tb_sccb_cfg_sequencer;

    localparam int RETRY_MAX = 3;
    localparam int MS_TICKS  = 100;
    localparam int PWR_TICKS = 100;
    localparam int GAP_TICKS = 2;
    localparam int NENT      = 3;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        start          = 1'b0;
    logic [23:0] lut_data       = '0;
    logic        trans_finished = 1'b0;
    logic        ack            = 1'b0;
    logic [7:0]  lut_index;
    logic        sclk_100k;
    logic        i2c_negclk;
    logic        en;
    logic [23:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_cnt;
    logic [2:0]  dbg_state;

    sccb_cfg_sequencer #(
        .CLK_FREQ (1_000_000),
        .SCCB_FREQ(100_000),
        .LUT_SIZE (8'd3),
        .PWR_MS   (1),
        .RETRY_MAX(RETRY_MAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .lut_index     (lut_index),
        .lut_data      (lut_data),
        .sclk_100k     (sclk_100k),
        .i2c_negclk    (i2c_negclk),
        .en            (en),
        .wr_data       (wr_data),
        .trans_finished(trans_finished),
        .ack           (ack),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_cnt       (err_cnt),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- clock / reset / models ----------------
    logic [23:0] tbl [NENT];
    int          nack_budget [NENT];
    int          attempts [NENT];

    always @(posedge clk) lut_data <= (lut_index < NENT) ? tbl[lut_index] : 24'h0;

    // Scoreboard entries: {ticks since pass start or previous en fall, index, data}
    logic [63:0] exp_q[$];
    logic [63:0] exp_item;
    logic        exp_err;
    int          exp_err_cnt;
    int          checks   = 0;
    int          failures = 0;
    int          tick_cnt = 0;
    int          wr_seen  = 0;
    int          lat      = 0;
    int          drop     = 0;
    logic        en_prev  = 1'b0;
    logic [23:0] cur_wr   = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev        = 1'b0;
            tick_cnt       = 0;
            trans_finished = 1'b0;
            ack            = 1'b0;
            lat            = 0;
            drop           = 0;
        end else begin
            if (start && !busy) begin
                tick_cnt = 0;
            end else if (en && !en_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write idx=%0d data=%h ticks=%0d, none expected",
                             lut_index, wr_data, tick_cnt);
                end else begin
                    exp_item = exp_q.pop_front();
                    if (wr_data !== exp_item[23:0] || lut_index !== exp_item[31:24] ||
                        tick_cnt != int'(exp_item[63:32])) begin
                        failures++;
                        $display("FAIL write_%0d got idx=%0d data=%h ticks=%0d, expected idx=%0d data=%h ticks=%0d",
                                 wr_seen, lut_index, wr_data, tick_cnt,
                                 exp_item[31:24], exp_item[23:0], exp_item[63:32]);
                    end
                end
                checks++;
                if (trans_finished !== 1'b0) begin
                    failures++;
                    $display("FAIL en_while_finished got trans_finished=%b, expected 0", trans_finished);
                end
                cur_wr = wr_data;
                wr_seen++;
                if (lut_index < NENT) attempts[lut_index]++;
                lat = $urandom_range(2, 6);
            end else if (!en && en_prev) begin
                tick_cnt = i2c_negclk ? 1 : 0;
            end else if (!en && i2c_negclk) begin
                tick_cnt++;
            end

            if (en && !trans_finished) begin
                if (lat > 0) lat--;
                if (lat == 0) begin
                    trans_finished = 1'b1;
                    ack  = (lut_index < NENT) ? (attempts[lut_index] <= nack_budget[lut_index]) : 1'b0;
                    drop = $urandom_range(1, 4);
                    checks++;
                    if (wr_data !== cur_wr) begin
                        failures++;
                        $display("FAIL wr_data_stable got %h, expected %h", wr_data, cur_wr);
                    end
                end
            end else if (!en && trans_finished) begin
                drop--;
                if (drop <= 0) begin
                    trans_finished = 1'b0;
                    ack            = 1'b0;
                end
            end
            en_prev = en;
        end
    end

    // ---------------- reference model ----------------
    task automatic build_expected();
        int pend;
        int nw;
        exp_q.delete();
        exp_err     = 1'b0;
        exp_err_cnt = 0;
        pend        = PWR_TICKS;
        for (int i = 0; i < NENT; i++) begin
            attempts[i] = 0;
            if (tbl[i][23:16] == 8'hFF) begin
                pend += MS_TICKS * int'(tbl[i][7:0]);
            end else begin
                nw = (nack_budget[i] > RETRY_MAX) ? RETRY_MAX + 1 : nack_budget[i] + 1;
                if (nack_budget[i] > RETRY_MAX) begin
                    exp_err = 1'b1;
                    exp_err_cnt++;
                end
                for (int a = 0; a < nw; a++) begin
                    exp_q.push_back({32'(pend), 8'(i), tbl[i]});
                    pend = GAP_TICKS;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
    endtask

    task automatic load_basic();
        tbl[0] = 24'h42_12_80;
        tbl[1] = 24'h42_11_01;
        tbl[2] = 24'h42_0C_10;
        for (int i = 0; i < NENT; i++) nack_budget[i] = 0;
    endtask

    task automatic run_pass(input bit spam, input string tag);
        int cyc;
        build_expected();
        wr_seen = 0;
        pulse_start();
        checks++;
        if ({busy, done, err, err_cnt, lut_index} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            failures++;
            $display("FAIL %s_start_clear got busy=%b done=%b err=%b err_cnt=%0d idx=%0d, expected 1 0 0 0 0",
                     tag, busy, done, err, err_cnt, lut_index);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(posedge clk); #2;
            start = spam && busy && ($urandom_range(0, 15) == 0);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout got done=%b after %0d cycles, expected 1", tag, done, cyc);
        end
        checks++;
        if ({busy, en, err, err_cnt, lut_index} !== {1'b0, 1'b0, exp_err, 8'(exp_err_cnt), 8'(NENT)}) begin
            failures++;
            $display("FAIL %s_end got busy=%b en=%b err=%b err_cnt=%0d idx=%0d, expected 0 0 %b %0d %0d",
                     tag, busy, en, err, err_cnt, lut_index, exp_err, exp_err_cnt, NENT);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_writes got %0d writes, %0d expected writes never seen",
                     tag, wr_seen, exp_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({en, busy, done, err, err_cnt, lut_index, wr_data, sclk_100k, i2c_negclk} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 24'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got en=%b busy=%b done=%b err=%b cnt=%0d idx=%0d wr=%h sclk=%b neg=%b, expected 0 0 0 0 0 0 0 1 0",
                     en, busy, done, err, err_cnt, lut_index, wr_data, sclk_100k, i2c_negclk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            #1;
            checks++;
            if (sclk_100k !== ((k % 10) < 5) || i2c_negclk !== ((k % 10) == 4)) begin
                failures++;
                $display("FAIL clock_phase_%0d got sclk=%b neg=%b, expected sclk=%b neg=%b",
                         k, sclk_100k, i2c_negclk, (k % 10) < 5, (k % 10) == 4);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        load_basic();
        run_pass(1'b0, "basic");
    endtask

    task automatic test_delay();
        load_basic();
        tbl[1] = 24'hFF_00_02;
        run_pass(1'b0, "delay");
    endtask

    task automatic test_retry();
        load_basic();
        nack_budget[0] = 99;
        run_pass(1'b0, "retry");
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        load_basic();
        build_expected();
        wr_seen = 0;
        pulse_start();
        cyc = 0;
        while (wr_seen < 2 && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        checks++;
        if (en !== 1'b1) begin
            failures++;
            $display("FAIL midwrite_en_before got en=%b wr_seen=%0d, expected en=1", en, wr_seen);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en, busy, lut_index, wr_data} !== {1'b0, 1'b0, 8'd0, 24'd0}) begin
            failures++;
            $display("FAIL midwrite_async got en=%b busy=%b idx=%0d wr=%h, expected 0 0 0 0",
                     en, busy, lut_index, wr_data);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        run_pass(1'b0, "after_reset");
    endtask

    task automatic test_start_ignored();
        load_basic();
        nack_budget[1] = 2;
        run_pass(1'b1, "start_spam");
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < NENT; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    tbl[i] = {8'hFF, 8'($urandom), 8'($urandom_range(0, 1))};
                end else begin
                    tbl[i] = {8'($urandom_range(0, 254)), 16'($urandom)};
                end
                nack_budget[i] = $urandom_range(0, 5);
            end
            run_pass(it[0], "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay();
        test_retry();
        test_reset_mid_write();
        test_start_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900_000;
        failures++;
        $display("FAIL watchdog simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
